uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
// - Buffered UART transmitter, the transmit-side counterpart of the UART receive path; drives the serial line that loops back into the RX in uart_top.
// - Accepts bytes over a valid/ready handshake into a small synchronous FIFO and serialises them LSB-first as 8-bit frames.
// - Frame: start bit, 8 data bits, optional parity bit, 1 or 2 stop bits. Queued bytes go out back-to-back with no idle gap.
// PARAMETERS
// - CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); legal range >= 2
// - FIFO_DEPTH    8    byte entries; power of 2, >= 2
// - PARITY_EN     0    1 = insert parity bit after data bits
// - PARITY_ODD    0    0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
// - STOP_BITS     1    1 or 2
// PORTS
// - clk         in   1                    system clock; all logic on rising edge
// - reset       in   1                    synchronous, active-low reset
// - tx_data     in   8                    byte to enqueue
// - tx_valid    in   1                    tx_data valid this cycle
// - tx_ready    out  1                    FIFO can accept; push = tx_valid & tx_ready
// - tx          out  1                    serial line, idle high, registered
// - tx_busy     out  1                    high while a frame is on the line or FIFO non-empty
// - fifo_count  out  $clog2(FIFO_DEPTH)+1 bytes queued, not counting the frame in flight
// BEHAVIOUR
// - Reset (reset == 0 at a clk edge): tx = 1, tx_ready = 0 during reset then 1 on first cycle after release, tx_busy = 0, fifo_count = 0, FSM in IDLE. Pointers and the baud counter clear. An in-flight frame is abandoned and the line returns high on the next edge.
// - FIFO: tx_ready = !full, registered from count.
//   - Push while full is ignored. tx_ready is low in that case, so the byte is not accepted.
//   - Pop occurs only when the FSM loads a byte.
//   - Push and pop in the same cycle leave the count unchanged. Full means count == FIFO_DEPTH.
//   - Pointers wrap modulo FIFO_DEPTH.
// - FSM states (encoding in uart_pkg): IDLE, START, DATA, PARITY, STOP.
//   - IDLE: tx = 1. If FIFO non-empty: pop, load shift reg, clear parity accumulator, go to START.
//   - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx = 0.
//   - DATA: tx = shift[0] for CLKS_PER_BIT cycles. Shift right and increment bit_idx. After bit 7, go to PARITY if PARITY_EN, else STOP.
//   - PARITY: tx = ^byte ^ PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
//   - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go straight to START (no idle bit); else go to IDLE.
// - Baud counter: loads CLKS_PER_BIT-1 on each state or bit entry and counts down. The bit ends when the counter is 0. Width is $clog2(CLKS_PER_BIT).
// - Latency: byte pushed at edge N into an empty, idle block; FSM pops at edge N+1; tx falls at edge N+2.
// - Frame length: (10 + PARITY_EN + STOP_BITS-1) * CLKS_PER_BIT clk cycles exactly.
// - tx_busy = (state != IDLE) | (fifo_count != 0).
// - tx_data is sampled only on a push; later changes do not affect queued bytes.
// STRUCTURE
// - uart_pkg: FSM state enum, DATA_BITS = 8, and shared helpers.
// - Sub-module uart_tx_fifo: synchronous FIFO (DEPTH, WIDTH = 8) with push/pop/full/empty/count and no first-word fall-through. This module contains the serialiser FSM, shift reg, baud counter and parity.
// TESTING (override CLKS_PER_BIT = 4, FIFO_DEPTH = 4)
// - Reset held 8 clks -> tx = 1, tx_ready = 1 after release, tx_busy = 0, fifo_count = 0.
// - Push 0x55, 8N1 -> tx low 2 edges after push. Line shows 0,1,0,1,0,1,0,1,0,1 (4 clks each), 40-clk frame. RX loopback reads 0x55.
// - Push 0xA5, PARITY_EN = 1, PARITY_ODD = 0 -> parity bit = 0. With PARITY_ODD = 1 -> parity bit = 1. Frame is 44 clks.
// - Push 5 bytes 0x01..0x05 on consecutive cycles -> tx_ready drops after the 4th queued byte while the 1st is in flight. All 5 frames arrive back-to-back with stop->start adjacent and no idle bit.
// - Simultaneous push and pop (push during the last STOP cycle with count = 2) -> count stays 2, byte order preserved.
// - reset asserted mid DATA bit 3 -> tx = 1 next edge, FIFO empty. A new push afterwards transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the serialiser state encoding and frame geometry helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic is_last_data_bit(input logic [2:0] idx);
        return idx == 3'(DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser.
// Read data is registered on pop; tx_ready is registered from next count.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   ready_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q;
    logic             ready_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Control registers: pointers, count, ready flag and read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
            if (pop_ok) begin
                rdata_q <= mem_q[rptr_q];
            end
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO plus LSB-first frame serialiser.
// The line is registered, so it trails the FSM state by one cycle.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          pop;
    logic          load;
    logic          bit_done;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .ready_o (tx_ready),
        .count_o (fifo_count)
    );

    assign bit_done = (baud_q == '0);
    // A new byte is taken from idle or on the very last stop cycle.
    assign load = ~fifo_empty &
                  ((state_q == ST_IDLE) |
                   ((state_q == ST_STOP) & bit_done & (bit_q == LAST_STOP)));

    // State register plus serialiser datapath and the registered line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state: bit timing, shifting and parity accumulation.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q != ST_IDLE && !bit_done) begin
            baud_d = baud_q - 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    par_d   = 1'b0;
                    baud_d  = BAUD_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    shift_d = fifo_rdata;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    if (is_last_data_bit(bit_q)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_q != LAST_STOP) begin
                        bit_d  = bit_q + 1'b1;
                        baud_d = BAUD_LOAD;
                    end else if (load) begin
                        bit_d   = '0;
                        par_d   = 1'b0;
                        baud_d  = BAUD_LOAD;
                        state_d = ST_START;
                    end else begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: line level for the current state and the FIFO pop strobe.
    always_comb begin
        tx_d = 1'b1;
        pop  = load;
        unique case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q ^ (PARITY_ODD != 0);
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered in 8N1, 8E1 and 8O2 builds.
// Models schedule each accepted byte's frame start from push time.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] d;
        int         s;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] line;
    logic [2:0] busy;
    logic [7:0] dat [3];
    logic [2:0] cnt [3];

    int errors = 0;
    int checks = 0;

    logic [7:0] stim_d [$];
    int         stim_g [$];

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input int k,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0h want %0h",
                     nm, k, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int PE    = (g != 0) ? 1 : 0;
        localparam int PO    = (g == 2) ? 1 : 0;
        localparam int SB    = (g == 2) ? 2 : 1;
        localparam int NB    = 10 + PE + SB - 1;
        localparam int FRAME = NB * CPB;

        uart_tx_buffered #(
            .CLKS_PER_BIT (CPB),
            .FIFO_DEPTH   (DEPTH),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .tx_data    (dat[g]),
            .tx_valid   (vld[g]),
            .tx_ready   (rdy[g]),
            .tx         (line[g]),
            .tx_busy    (busy[g]),
            .fifo_count (cnt[g])
        );

        ent_t mq [$];
        ent_t rq [$];
        ent_t en;
        ent_t ex;
        int   e        = 0;
        int   last_end = 0;
        int   m_count  = 0;
        bit   m_ready  = 1'b0;
        bit   m_busy   = 1'b0;

        // Reference model: frame start = max(push + 2, previous frame end).
        initial begin : model
            forever begin
                @(posedge clk);
                e++;
                if (!reset) begin
                    mq.delete();
                    rq.delete();
                    last_end = 0;
                    m_count  = 0;
                    m_ready  = 1'b0;
                    m_busy   = 1'b0;
                end else begin
                    if (vld[g] && m_ready) begin
                        en.d = dat[g];
                        en.s = (e + 2 > last_end) ? e + 2 : last_end;
                        last_end = en.s + FRAME;
                        mq.push_back(en);
                        rq.push_back(en);
                    end
                    while (mq.size() > 0 && mq[0].s - 1 + FRAME <= e)
                        void'(mq.pop_front());
                    m_count = 0;
                    foreach (mq[i])
                        if (mq[i].s - 1 > e) m_count++;
                    m_busy  = (mq.size() != 0);
                    m_ready = (m_count < DEPTH);
                end
            end
        end

        // Per-cycle status comparison against the model.
        initial begin : status
            forever begin
                @(negedge clk);
                if (e > 0) begin
                    chk(rdy[g] == m_ready, "tx_ready", g, rdy[g], m_ready);
                    chk(cnt[g] == 3'(m_count), "fifo_count", g,
                        cnt[g], m_count);
                    chk(busy[g] == m_busy, "tx_busy", g, busy[g], m_busy);
                    if (e >= last_end)
                        chk(line[g] == 1'b1, "idle_line", g, line[g], 1);
                end
            end
        end

        logic [11:0] fb;
        logic [7:0]  rxd;
        int          bad;
        bit          ab;
        logic        v;

        // Line monitor: decodes each frame and checks timing and content.
        initial begin : rx
            forever begin
                @(negedge clk);
                if (reset && line[g] == 1'b0) begin
                    chk(rq.size() != 0, "spurious_start", g, e, 0);
                    if (rq.size() != 0) begin
                        ex = rq.pop_front();
                    end else begin
                        ex.d = 8'h00;
                        ex.s = e;
                    end
                    chk(e == ex.s, "start_edge", g, e, ex.s);
                    fb      = '1;
                    fb[0]   = 1'b0;
                    fb[8:1] = ex.d;
                    if (PE != 0) fb[9] = (^ex.d) ^ (PO != 0);
                    bad = 0;
                    ab  = 1'b0;
                    rxd = '0;
                    for (int b = 0; b < NB; b++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (!ab) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (!reset) begin
                                    ab = 1'b1;
                                end else begin
                                    v = line[g];
                                    if (c == 0 && b >= 1 && b <= 8)
                                        rxd[b-1] = v;
                                    if (v != fb[b]) bad++;
                                end
                            end
                        end
                    end
                    if (!ab) begin
                        chk(rxd == ex.d, "rx_byte", g, rxd, ex.d);
                        chk(bad == 0, "frame_bits", g, bad, 0);
                    end
                end
            end
        end
    end

    function automatic int frame_len(input int k);
        return (10 + ((k != 0) ? 1 : 0) + ((k == 2) ? 1 : 0)) * CPB;
    endfunction

    // Feeds the stimulus list to one DUT, honouring its own handshake.
    task automatic drive(input int k, input int mode);
        bit acc;
        int gap;
        for (int i = 0; i < stim_d.size(); i++) begin
            gap = stim_g[i];
            if (mode == 1 && i == 3) gap = frame_len(k) - 2;
            if (gap > 0) begin
                vld[k] = 1'b0;
                dat[k] = 8'($urandom);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            vld[k] = 1'b1;
            dat[k] = stim_d[i];
            acc = 1'b0;
            for (int t = 0; t < 2000 && !acc; t++) begin
                @(negedge clk);
                acc = rdy[k];
                @(posedge clk);
                #1;
            end
            chk(acc, "push_timeout", k, acc, 1);
        end
        vld[k] = 1'b0;
        dat[k] = 8'($urandom);
    endtask

    task automatic run(input int mode);
        fork
            drive(0, mode);
            drive(1, mode);
            drive(2, mode);
        join
    endtask

    task automatic set_stim(input logic [7:0] d [$], input int g [$]);
        stim_d = d;
        stim_g = g;
    endtask

    task automatic wait_idle();
        int quiet;
        bit ok;
        quiet = 0;
        ok = 1'b0;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk);
            if (busy == 3'b000 && line == 3'b111) quiet++;
            else quiet = 0;
            if (quiet >= 3) ok = 1'b1;
        end
        chk(ok, "idle_timeout", 0, ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        vld   = '0;
        for (int k = 0; k < 3; k++) dat[k] = 8'($urandom);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        set_stim('{8'h55}, '{0});
        run(0);
        wait_idle();

        set_stim('{8'hA5}, '{0});
        run(0);
        wait_idle();

        set_stim('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, '{0, 0, 0, 0, 0});
        run(0);
        wait_idle();

        set_stim('{8'h11, 8'h22, 8'h33, 8'h44}, '{0, 0, 0, 0});
        run(1);
        wait_idle();

        set_stim('{8'hC3, 8'h3C}, '{0, 0});
        run(0);
        repeat (18) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        set_stim('{8'h96}, '{0});
        run(0);
        wait_idle();

        stim_d.delete();
        stim_g.delete();
        for (int i = 0; i < 24; i++) begin
            stim_d.push_back(8'($urandom));
            stim_g.push_back(($urandom_range(0, 3) == 0) ?
                             int'($urandom_range(1, 60)) : 0);
        end
        run(0);
        wait_idle();

        chk(gd[0].rq.size() == 0, "frames_left", 0, gd[0].rq.size(), 0);
        chk(gd[1].rq.size() == 0, "frames_left", 1, gd[1].rq.size(), 0);
        chk(gd[2].rq.size() == 0, "frames_left", 2, gd[2].rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
